// File: rtl/eth_sync_arbiter_if.sv
// Bus between the configuration sources and the synchronizer arbiter.
interface eth_sync_arbiter_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDW   = 2
);
  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] data;
  logic                 ena_buf;
  logic [IDW+WIDTH-1:0] dout;
  logic [NCH-1:0]       sent;
  logic [NCH-1:0]       pending;
  logic                 busy;

  // Source side: posts updates, observes issue status.
  modport master (
    output req, data,
    input  ena_buf, dout, sent, pending, busy
  );

  // Arbiter side.
  modport slave (
    input  req, data,
    output ena_buf, dout, sent, pending, busy
  );
endinterface

// File: rtl/eth_sync_arbiter.sv
// Round-robin arbiter sharing one bus synchronizer among NCH config sources.
// Holds the latest value per channel and issues {id, data} spaced by GAP.
module eth_sync_arbiter #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDW   = 2,
  parameter int unsigned GAP   = 16
) (
  input  logic                clk,
  input  logic                res,
  eth_sync_arbiter_if.slave   bus
);

  localparam int unsigned CNTW = $clog2(GAP) + 1;
  localparam int unsigned DW   = IDW + WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_issue;
  logic [IDW-1:0]    w_grant;
  logic [IDW-1:0]    w_pick;
  logic [IDW-1:0]    r_grant;
  logic [IDW-1:0]    r_ptr;
  logic [CNTW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_hold [NCH];
  logic [NCH-1:0]    r_pending;
  logic              r_ena;
  logic [DW-1:0]     r_dout;
  logic [NCH-1:0]    r_sent;
  logic              r_busy;

  // First pending channel searching from the round-robin pointer upward.
  always_comb begin
    logic           v_found;
    logic [IDW-1:0] v_idx;
    w_pick  = r_ptr;
    v_found = 1'b0;
    v_idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      v_idx = IDW'((32'(r_ptr) + k) % NCH);
      if (!v_found && r_pending[v_idx]) begin
        v_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (res) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and grant decode.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_grant = r_grant;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_grant = w_pick;
          w_next  = ISSUE;
        end
      end
      ISSUE: begin
        w_issue = 1'b1;
        w_next  = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture, issue datapath, guard counter and registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      r_grant   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_pending <= '0;
      r_ena     <= 1'b0;
      r_dout    <= '0;
      r_sent    <= '0;
      r_busy    <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) r_hold[i] <= '0;
    end else begin
      r_grant <= w_grant;
      r_ena   <= w_issue;
      r_sent  <= w_issue ? (NCH'(1) << r_grant) : '0;
      r_busy  <= (w_next != IDLE);
      if (w_issue) begin
        r_dout <= {r_grant, r_hold[r_grant]};
        r_ptr  <= (r_grant == IDW'(NCH - 1)) ? '0 : r_grant + IDW'(1);
        r_cnt  <= CNTW'(GAP - 1);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNTW'(1);
      end
      // A same-cycle req on the issued channel wins: keep it pending.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (bus.req[i]) begin
          r_hold[i]    <= bus.data[i*WIDTH +: WIDTH];
          r_pending[i] <= 1'b1;
        end else if (w_issue && r_grant == IDW'(i)) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.ena_buf = r_ena;
  assign bus.dout    = r_dout;
  assign bus.sent    = r_sent;
  assign bus.pending = r_pending;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_eth_sync_arbiter.sv
// Scoreboard bench for eth_sync_arbiter: timing-level reference model
// predicts every issue; a negedge monitor compares outputs against it.
module tb_eth_sync_arbiter;

  localparam int unsigned NCH   = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDW   = 2;
  localparam int unsigned GAP   = 16;
  localparam int unsigned DW    = IDW + WIDTH;

  logic clk;
  logic res;

  eth_sync_arbiter_if #(.NCH(NCH), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  eth_sync_arbiter #(.NCH(NCH), .WIDTH(WIDTH), .IDW(IDW), .GAP(GAP)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: issue times derived from edge arithmetic.
  int               edge_n;
  logic [WIDTH-1:0] m_hold [NCH];
  logic [NCH-1:0]   m_pend;
  int               m_ptr;
  int               m_gnt;
  int               m_gnt_edge;
  int               m_free;
  int               m_busy_until;
  logic             m_busy;
  logic             m_ena;
  logic [DW-1:0]    m_dout;
  logic [DW-1:0]    exp_q [$];

  initial begin
    edge_n = 0; m_pend = '0; m_ptr = 0; m_gnt = 0; m_gnt_edge = -10;
    m_free = 0; m_busy_until = -1; m_busy = 1'b0; m_ena = 1'b0; m_dout = '0;
    for (int i = 0; i < NCH; i++) m_hold[i] = '0;
  end

  always @(posedge clk) begin
    edge_n++;
    m_ena = 1'b0;
    if (res) begin
      m_pend = '0; m_ptr = 0; m_gnt_edge = -10; m_free = edge_n + 1;
      m_busy_until = -1; m_busy = 1'b0; m_dout = '0;
      for (int i = 0; i < NCH; i++) m_hold[i] = '0;
      exp_q.delete();
    end else begin
      if (m_gnt_edge == edge_n - 1) begin
        m_dout = {IDW'(m_gnt), m_hold[m_gnt]};
        exp_q.push_back(m_dout);
        m_ena = 1'b1;
        m_pend[m_gnt] = 1'b0;
        m_ptr = (m_gnt + 1) % NCH;
        m_free = edge_n + GAP + 1;
        m_busy_until = edge_n + GAP - 1;
      end else if (edge_n >= m_free && |m_pend) begin
        for (int k = 0; k < NCH; k++) begin
          if (m_gnt_edge != edge_n && m_pend[(m_ptr + k) % NCH]) begin
            m_gnt = (m_ptr + k) % NCH;
            m_gnt_edge = edge_n;
          end
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (bus.req[i]) begin
          m_hold[i] = bus.data[i*WIDTH +: WIDTH];
          m_pend[i] = 1'b1;
        end
      end
      m_busy = (m_gnt_edge == edge_n) || (edge_n <= m_busy_until);
    end
  end

  // Monitor: pops the scoreboard on every ena_buf, checks status each cycle.
  logic [DW-1:0] mon_exp;
  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("ena_buf", 64'(bus.ena_buf), 64'(m_ena));
      chk("pending", 64'(bus.pending), 64'(m_pend));
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("dout_held", 64'(bus.dout), 64'(m_dout));
      if (bus.ena_buf) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 64'(bus.dout), 64'hDEAD);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("issue_dout", 64'(bus.dout), 64'(mon_exp));
          chk("issue_sent", 64'(bus.sent), 64'(NCH'(1) << mon_exp[DW-1 -: IDW]));
        end
      end else begin
        chk("sent_idle", 64'(bus.sent), 64'h0);
      end
    end
  end

  task automatic drive(input logic [NCH-1:0] m, input logic [NCH*WIDTH-1:0] d);
    bus.req  = m;
    bus.data = d;
    @(negedge clk);
    bus.req  = '0;
  endtask

  task automatic idle(input int n);
    bus.req = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    res      = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ena", 64'(bus.ena_buf), 64'h0);
    chk("rst_dout", 64'(bus.dout), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    res = 1'b0;
    @(negedge clk);

    // Single update on ch2: issue two edges after capture.
    drive(4'b0100, {16'h0, 16'h1234, 16'h0, 16'h0});
    @(negedge clk);
    @(negedge clk);
    chk("t1_ena", 64'(bus.ena_buf), 64'h1);
    chk("t1_dout", 64'(bus.dout), 64'h2_1234);
    chk("t1_sent", 64'(bus.sent), 64'b0100);
    chk("t1_pend", 64'(bus.pending), 64'h0);
    @(negedge clk);
    chk("t1_ena_off", 64'(bus.ena_buf), 64'h0);
    idle(GAP + 4);

    // All four channels at once.
    drive(4'b1111, {16'h000D, 16'h000C, 16'h000B, 16'h000A});
    idle(4 * (GAP + 2) + 6);

    // Overwrite of ch1 while a ch0 issue is in its guard interval.
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'h7777});
    idle(3);
    drive(4'b0010, {16'h0, 16'h0, 16'h1111, 16'h0});
    idle(2);
    drive(4'b0010, {16'h0, 16'h0, 16'hBEEF, 16'h0});
    idle(2 * (GAP + 2) + 6);

    // New ch2 value arriving exactly in ch2's issue cycle.
    drive(4'b0100, {16'h0, 16'h4444, 16'h0, 16'h0});
    @(negedge clk);
    drive(4'b0100, {16'h0, 16'h5555, 16'h0, 16'h0});
    chk("t4_pend", 64'(bus.pending), 64'b0100);
    idle(2 * (GAP + 2) + 6);

    // Continuous ch0 requester must not starve ch3.
    bus.data = {16'h3333, 16'h0, 16'h0, 16'h0A0A};
    bus.req  = 4'b0001;
    repeat (5) @(negedge clk);
    bus.req  = 4'b1001;
    @(negedge clk);
    bus.req  = 4'b0001;
    repeat (4 * (GAP + 2)) @(negedge clk);
    idle(2 * (GAP + 2) + 6);

    // Reset with ch1/ch2 pending during the guard interval.
    drive(4'b0001, {16'h0, 16'h0, 16'h0, 16'h0101});
    idle(4);
    drive(4'b0110, {16'h0, 16'h2222, 16'h1212, 16'h0});
    idle(2);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("t6_pend", 64'(bus.pending), 64'h0);
    chk("t6_dout", 64'(bus.dout), 64'h0);
    chk("t6_busy", 64'(bus.busy), 64'h0);
    idle(50);

    // Random traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      logic [NCH-1:0] m;
      for (int i = 0; i < NCH; i++) m[i] = ($urandom_range(0, 7) == 0);
      bus.req  = m;
      bus.data = {$urandom(), $urandom()};
      res      = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    res = 1'b0;
    idle(NCH * (GAP + 2) + 20);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
